// File: rtl/bus_m_arb2_if.sv
`default_nettype none
// ============================================================================
// Module   : bus_m_arb2_if
// Brief    : BUS_M command/response bundle; master drives the command,
//            slave returns acknowledge, last, read data and done.
// Revision : 1.0
// ============================================================================
interface bus_m_arb2_if;
  logic        req;
  logic        ack;
  logic        seq;
  logic        cont;
  logic        lock;
  logic        write;
  logic [2:0]  burst;
  logic [3:0]  prot;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        last;
  logic [31:0] rdata;
  logic [3:0]  done;

  modport master (
    output req, seq, cont, lock, write, burst, prot, size, addr, wdata,
    input  ack, last, rdata, done
  );

  modport slave (
    input  req, seq, cont, lock, write, burst, prot, size, addr, wdata,
    output ack, last, rdata, done
  );
endinterface
`default_nettype wire

// File: rtl/bus_m_arb2.sv
`default_nettype none
// ============================================================================
// Module   : bus_m_arb2
// Brief    : Two-source BUS_M arbiter with burst/lock grant hold and
//            data-phase / done-cycle response routing.
// Revision : 1.0
// ============================================================================
module bus_m_arb2 #(
  parameter bit FIXED_PRI = 1'b0
) (
  input wire           CLK,
  input wire           RES_SYS,
  bus_m_arb2_if.slave  s0,
  bus_m_arb2_if.slave  s1,
  bus_m_arb2_if.master m
);

  typedef enum logic [0:0] {
    ST_OPEN = 1'b0,
    ST_HELD = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_owner;
  logic   r_last_win;
  logic   r_dph_own;
  logic   r_done_own;
  logic   w_sel;
  logic   w_sel_hold;

  // With nobody requesting, stay parked on the previous winner.
  always_comb begin
    w_sel = r_last_win;
    if (r_state == ST_HELD)          w_sel = r_owner;
    else if (s0.req && !s1.req)      w_sel = 1'b0;
    else if (!s0.req && s1.req)      w_sel = 1'b1;
    else if (s0.req && s1.req)       w_sel = FIXED_PRI ? 1'b0 : ~r_last_win;
  end

  assign w_sel_hold = w_sel ? (s1.lock | s1.cont) : (s0.lock | s0.cont);

  always_comb begin
    w_state_nxt = r_state;
    if (m.ack) w_state_nxt = w_sel_hold ? ST_HELD : ST_OPEN;
  end

  always_ff @(posedge CLK or posedge RES_SYS) begin
    if (RES_SYS) r_state <= ST_OPEN;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge CLK or posedge RES_SYS) begin
    if (RES_SYS) begin
      r_owner    <= 1'b0;
      r_last_win <= 1'b1;
      r_dph_own  <= 1'b0;
      r_done_own <= 1'b0;
    end else begin
      if (m.ack) begin
        r_owner    <= w_sel;
        r_last_win <= w_sel;
        r_dph_own  <= w_sel;
      end
      // Samples the pre-update data-phase owner, so an overlapping ack
      // never steals the done cycle of the transfer that is finishing.
      if (m.last) r_done_own <= r_dph_own;
    end
  end

  // CONT follows the selected source even without REQ: BUSY inside a burst.
  assign m.req   = w_sel ? s1.req   : s0.req;
  assign m.seq   = w_sel ? s1.seq   : s0.seq;
  assign m.cont  = w_sel ? s1.cont  : s0.cont;
  assign m.lock  = w_sel ? s1.lock  : s0.lock;
  assign m.write = w_sel ? s1.write : s0.write;
  assign m.burst = w_sel ? s1.burst : s0.burst;
  assign m.prot  = w_sel ? s1.prot  : s0.prot;
  assign m.size  = w_sel ? s1.size  : s0.size;
  assign m.addr  = w_sel ? s1.addr  : s0.addr;
  assign m.wdata = w_sel ? s1.wdata : s0.wdata;

  assign s0.ack   = m.ack & ~w_sel;
  assign s1.ack   = m.ack &  w_sel;
  assign s0.last  = m.last & ~r_dph_own;
  assign s1.last  = m.last &  r_dph_own;
  assign s0.done  = r_done_own ? 4'h0  : m.done;
  assign s1.done  = r_done_own ? m.done : 4'h0;
  assign s0.rdata = r_done_own ? 32'h0 : m.rdata;
  assign s1.rdata = r_done_own ? m.rdata : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_bus_m_arb2.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_bus_m_arb2
// Brief    : Directed scenarios plus randomized traffic against a queue-level
//            reference model for the two-source BUS_M arbiter.
// Revision : 1.0
// ============================================================================
module tb_bus_m_arb2;

  logic CLK = 1'b0;
  logic RES_SYS = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 CLK = ~CLK;

  bus_m_arb2_if a0 ();
  bus_m_arb2_if a1 ();
  bus_m_arb2_if am ();
  bus_m_arb2_if b0 ();
  bus_m_arb2_if b1 ();
  bus_m_arb2_if bm ();

  bus_m_arb2 #(.FIXED_PRI(1'b0)) u_rr (.CLK(CLK), .RES_SYS(RES_SYS), .s0(a0), .s1(a1), .m(am));
  bus_m_arb2 #(.FIXED_PRI(1'b1)) u_fp (.CLK(CLK), .RES_SYS(RES_SYS), .s0(b0), .s1(b1), .m(bm));

  task automatic clear_inputs();
    a0.req = 0; a0.seq = 0; a0.cont = 0; a0.lock = 0; a0.write = 0; a0.burst = 0;
    a0.prot = 0; a0.size = 0; a0.addr = 0; a0.wdata = 0;
    a1.req = 0; a1.seq = 0; a1.cont = 0; a1.lock = 0; a1.write = 0; a1.burst = 0;
    a1.prot = 0; a1.size = 0; a1.addr = 0; a1.wdata = 0;
    b0.req = 0; b0.seq = 0; b0.cont = 0; b0.lock = 0; b0.write = 0; b0.burst = 0;
    b0.prot = 0; b0.size = 0; b0.addr = 0; b0.wdata = 0;
    b1.req = 0; b1.seq = 0; b1.cont = 0; b1.lock = 0; b1.write = 0; b1.burst = 0;
    b1.prot = 0; b1.size = 0; b1.addr = 0; b1.wdata = 0;
    am.ack = 0; am.last = 0; am.rdata = 0; am.done = 0;
    bm.ack = 0; bm.last = 0; bm.rdata = 0; bm.done = 0;
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RES_SYS = 1'b1;
    clear_inputs();
    @(negedge CLK);
    RES_SYS = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] resp;
    clear_inputs();
    a0.cont = 1'b1;
    @(negedge CLK); #1;
    resp = {a0.ack, a1.ack, a0.last, a1.last, a0.done, a1.done};
    n_cmp++; if (resp !== 12'h0) begin n_err++; $display("FAIL reset_resp: got %h want 000", resp); end
    n_cmp++; if (a0.rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata0: got %h want 0", a0.rdata); end
    n_cmp++; if (a1.rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata1: got %h want 0", a1.rdata); end
    n_cmp++; if (am.req !== 1'b0) begin n_err++; $display("FAIL reset_mreq: got %b want 0", am.req); end
    n_cmp++; if (am.cont !== 1'b0) begin n_err++; $display("FAIL reset_mcont: got %b want 0", am.cont); end
    RES_SYS = 1'b0;
    @(negedge CLK); #1;
    n_cmp++; if (am.cont !== 1'b0) begin n_err++; $display("FAIL reset_mcont_idle: got %b want 0", am.cont); end
    clear_inputs();
  endtask

  task automatic test_round_robin();
    logic        s0_turn;
    logic [3:0]  exp_d0, exp_d1;
    logic [31:0] exp_r0, exp_r1;
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      a0.req = 1; a0.size = 2'd2; a0.addr = 32'h1000 + 32'(k);
      a1.req = 1; a1.size = 2'd2; a1.addr = 32'h2000 + 32'(k);
      am.ack = 1; am.last = (k >= 1);
      am.done  = (k >= 2) ? 4'b0001 : 4'b0000;
      am.rdata = (k >= 2) ? (((k - 2) % 2 == 0) ? 32'h11111111 : 32'h22222222) : 32'h0;
      #1;
      s0_turn = (k % 2 == 0);
      n_cmp++; if (a0.ack !== s0_turn) begin n_err++; $display("FAIL rr_ack0 c%0d: got %b want %b", k, a0.ack, s0_turn); end
      n_cmp++; if (a1.ack !== !s0_turn) begin n_err++; $display("FAIL rr_ack1 c%0d: got %b want %b", k, a1.ack, !s0_turn); end
      n_cmp++; if (am.addr !== (s0_turn ? 32'h1000 : 32'h2000) + 32'(k)) begin n_err++; $display("FAIL rr_addr c%0d: got %h", k, am.addr); end
      if (k >= 1) begin
        n_cmp++;
        if ({a0.last, a1.last} !== (((k - 1) % 2 == 0) ? 2'b10 : 2'b01)) begin
          n_err++; $display("FAIL rr_last c%0d: got %b%b", k, a0.last, a1.last);
        end
      end
      if (k >= 2) begin
        exp_d0 = ((k - 2) % 2 == 0) ? 4'b0001 : 4'b0000;
        exp_d1 = ((k - 2) % 2 == 0) ? 4'b0000 : 4'b0001;
        exp_r0 = ((k - 2) % 2 == 0) ? 32'h11111111 : 32'h0;
        exp_r1 = ((k - 2) % 2 == 0) ? 32'h0 : 32'h22222222;
        n_cmp++; if (a0.done !== exp_d0) begin n_err++; $display("FAIL rr_done0 c%0d: got %b want %b", k, a0.done, exp_d0); end
        n_cmp++; if (a1.done !== exp_d1) begin n_err++; $display("FAIL rr_done1 c%0d: got %b want %b", k, a1.done, exp_d1); end
        n_cmp++; if (a0.rdata !== exp_r0) begin n_err++; $display("FAIL rr_rdata0 c%0d: got %h want %h", k, a0.rdata, exp_r0); end
        n_cmp++; if (a1.rdata !== exp_r1) begin n_err++; $display("FAIL rr_rdata1 c%0d: got %h want %h", k, a1.rdata, exp_r1); end
      end
    end
    clear_inputs();
  endtask

  task automatic test_fixed_priority();
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      b0.req = (k < 4); b0.addr = 32'hF000_0000;
      b1.req = 1;       b1.addr = 32'hF111_0000;
      bm.ack = 1;
      #1;
      n_cmp++; if (b0.ack !== (k < 4)) begin n_err++; $display("FAIL fp_ack0 c%0d: got %b want %b", k, b0.ack, (k < 4)); end
      n_cmp++; if (b1.ack !== (k == 4)) begin n_err++; $display("FAIL fp_ack1 c%0d: got %b want %b", k, b1.ack, (k == 4)); end
      n_cmp++; if (bm.addr !== ((k < 4) ? 32'hF000_0000 : 32'hF111_0000)) begin n_err++; $display("FAIL fp_addr c%0d: got %h", k, bm.addr); end
    end
    clear_inputs();
  endtask

  task automatic test_held_burst();
    logic exp1;
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      a0.req = 1; a0.addr = 32'h0000_A000;
      a1.req = (k >= 1); a1.cont = (k >= 1 && k < 4); a1.addr = 32'h0000_B000;
      am.ack = 1;
      #1;
      exp1 = (k >= 1 && k <= 4);
      n_cmp++; if (a1.ack !== exp1) begin n_err++; $display("FAIL held_ack1 c%0d: got %b want %b", k, a1.ack, exp1); end
      n_cmp++; if (a0.ack !== !exp1) begin n_err++; $display("FAIL held_ack0 c%0d: got %b want %b", k, a0.ack, !exp1); end
      n_cmp++; if (am.cont !== (k >= 1 && k < 4)) begin n_err++; $display("FAIL held_cont c%0d: got %b", k, am.cont); end
    end
    clear_inputs();
  endtask

  task automatic test_busy();
    apply_reset();
    @(negedge CLK);
    a1.req = 1; a1.lock = 1; a1.cont = 1; a1.addr = 32'h0000_B000;
    am.ack = 1;
    #1;
    n_cmp++; if (a1.ack !== 1'b1) begin n_err++; $display("FAIL busy_grab: got %b want 1", a1.ack); end
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      a1.req = 0; a0.req = 1; a0.addr = 32'h0000_A000; am.ack = 0;
      #1;
      n_cmp++; if (am.req !== 1'b0) begin n_err++; $display("FAIL busy_mreq c%0d: got %b want 0", k, am.req); end
      n_cmp++; if (am.cont !== 1'b1) begin n_err++; $display("FAIL busy_mcont c%0d: got %b want 1", k, am.cont); end
      n_cmp++; if (am.addr !== 32'h0000_B000) begin n_err++; $display("FAIL busy_addr c%0d: got %h want 0000b000", k, am.addr); end
    end
    @(negedge CLK);
    a1.req = 1; a1.lock = 0; a1.cont = 0; am.ack = 1;
    #1;
    n_cmp++; if ({a0.ack, a1.ack} !== 2'b01) begin n_err++; $display("FAIL busy_release: got %b%b want 01", a0.ack, a1.ack); end
    @(negedge CLK);
    a1.req = 0;
    #1;
    n_cmp++; if ({a0.ack, a1.ack} !== 2'b10) begin n_err++; $display("FAIL busy_after: got %b%b want 10", a0.ack, a1.ack); end
    clear_inputs();
  endtask

  task automatic test_overlap();
    apply_reset();
    @(negedge CLK);
    a0.req = 1; a0.write = 1; a0.addr = 32'h0000_C000; am.ack = 1;
    #1;
    n_cmp++; if (a0.ack !== 1'b1) begin n_err++; $display("FAIL ovl_ack0: got %b want 1", a0.ack); end
    @(negedge CLK);
    a0.req = 0; a1.req = 1; a1.write = 0; am.ack = 0; am.last = 0;
    #1;
    n_cmp++; if ({a0.last, a1.last} !== 2'b00) begin n_err++; $display("FAIL ovl_wait: got %b%b want 00", a0.last, a1.last); end
    @(negedge CLK);
    am.ack = 1; am.last = 1;
    #1;
    n_cmp++; if (a1.ack !== 1'b1) begin n_err++; $display("FAIL ovl_ack1: got %b want 1", a1.ack); end
    n_cmp++; if ({a0.last, a1.last} !== 2'b10) begin n_err++; $display("FAIL ovl_last0: got %b%b want 10", a0.last, a1.last); end
    @(negedge CLK);
    a1.req = 0; am.ack = 0; am.last = 1; am.done = 4'b0011; am.rdata = 32'h5A5A5A5A;
    #1;
    n_cmp++; if (a0.done !== 4'b0011) begin n_err++; $display("FAIL ovl_done0: got %b want 0011", a0.done); end
    n_cmp++; if (a1.done !== 4'b0000) begin n_err++; $display("FAIL ovl_done1_quiet: got %b want 0000", a1.done); end
    n_cmp++; if ({a0.last, a1.last} !== 2'b01) begin n_err++; $display("FAIL ovl_last1: got %b%b want 01", a0.last, a1.last); end
    n_cmp++; if (a1.rdata !== 32'h0) begin n_err++; $display("FAIL ovl_rdata1_quiet: got %h want 0", a1.rdata); end
    @(negedge CLK);
    am.last = 0; am.done = 4'b0001; am.rdata = 32'hCAFEF00D;
    #1;
    n_cmp++; if (a1.done !== 4'b0001) begin n_err++; $display("FAIL ovl_done1: got %b want 0001", a1.done); end
    n_cmp++; if (a0.done !== 4'b0000) begin n_err++; $display("FAIL ovl_done0_quiet: got %b want 0000", a0.done); end
    n_cmp++; if (a1.rdata !== 32'hCAFEF00D) begin n_err++; $display("FAIL ovl_rdata1: got %h want cafef00d", a1.rdata); end
    n_cmp++; if (a0.rdata !== 32'h0) begin n_err++; $display("FAIL ovl_rdata0_quiet: got %h want 0", a0.rdata); end
    clear_inputs();
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    @(negedge CLK);
    a1.req = 1; a1.lock = 1; am.ack = 1;
    @(negedge CLK);
    a1.req = 0; am.ack = 0; am.last = 1;
    #1;
    n_cmp++; if (a1.last !== 1'b1) begin n_err++; $display("FAIL rst_mid_last1: got %b want 1", a1.last); end
    @(negedge CLK);
    RES_SYS = 1'b1;
    am.last = 0; am.rdata = 32'hDEADBEEF;
    #1;
    n_cmp++; if (a1.rdata !== 32'h0) begin n_err++; $display("FAIL rst_mid_async: got %h want 0", a1.rdata); end
    @(negedge CLK);
    RES_SYS = 1'b0;
    @(negedge CLK);
    a0.req = 1; a1.req = 1; a1.lock = 0; am.ack = 1; am.done = 0; am.rdata = 32'h77777777;
    #1;
    n_cmp++; if ({a0.ack, a1.ack} !== 2'b10) begin n_err++; $display("FAIL rst_mid_tie: got %b%b want 10", a0.ack, a1.ack); end
    n_cmp++; if ({a0.done, a1.done} !== 8'h00) begin n_err++; $display("FAIL rst_mid_done: got %h want 00", {a0.done, a1.done}); end
    n_cmp++; if (a1.rdata !== 32'h0) begin n_err++; $display("FAIL rst_mid_rdata1: got %h want 0", a1.rdata); end
    clear_inputs();
  endtask

  task automatic test_random();
    int          hold, last_g, dph_src, resp_src, g;
    bit          dph_busy, dph_wr, done_due, done_wr, ack, lst;
    bit          rq[2], ct[2], lk[2], wr[2];
    logic [31:0] ad[2];
    logic [31:0] rd;
    logic [3:0]  dn;
    logic [1:0]  exp_ack, exp_last;
    apply_reset();
    hold = -1; last_g = 1; dph_src = 0; resp_src = 0;
    dph_busy = 0; dph_wr = 0; done_due = 0; done_wr = 0;
    for (int k = 0; k < 600; k++) begin
      @(negedge CLK);
      for (int i = 0; i < 2; i++) begin
        rq[i] = ($urandom % 8) < 5; ct[i] = ($urandom % 4) == 0; lk[i] = ($urandom % 8) == 0;
        wr[i] = 1'($urandom); ad[i] = $urandom;
      end
      a0.req = rq[0]; a0.cont = ct[0]; a0.lock = lk[0]; a0.write = wr[0]; a0.addr = ad[0];
      a0.wdata = $urandom; a0.size = 2'($urandom % 3); a0.burst = 3'($urandom); a0.prot = 4'($urandom); a0.seq = 1'($urandom);
      a1.req = rq[1]; a1.cont = ct[1]; a1.lock = lk[1]; a1.write = wr[1]; a1.addr = ad[1];
      a1.wdata = $urandom; a1.size = 2'($urandom % 3); a1.burst = 3'($urandom); a1.prot = 4'($urandom); a1.seq = 1'($urandom);
      // winner: held owner, else lone requester, else alternate, else stay put
      if (hold >= 0)          g = hold;
      else if (rq[0] != rq[1]) g = rq[1] ? 1 : 0;
      else if (rq[0])         g = 1 - last_g;
      else                    g = last_g;
      lst = dph_busy && (($urandom % 2) == 1);
      ack = rq[g] && (!dph_busy || lst) && (($urandom % 4) != 0);
      dn  = done_due ? {1'($urandom), 1'($urandom), done_wr, 1'b1} : 4'h0;
      rd  = $urandom;
      am.ack = ack; am.last = lst; am.done = dn; am.rdata = rd;
      #1;
      exp_ack  = {ack && g == 0, ack && g == 1};
      exp_last = lst ? ((dph_src == 0) ? 2'b10 : 2'b01) : 2'b00;
      n_cmp++; if (am.req !== rq[g]) begin n_err++; $display("FAIL rnd_mreq c%0d: got %b want %b", k, am.req, rq[g]); end
      n_cmp++; if (am.cont !== ct[g]) begin n_err++; $display("FAIL rnd_mcont c%0d: got %b want %b", k, am.cont, ct[g]); end
      n_cmp++; if (am.addr !== ad[g]) begin n_err++; $display("FAIL rnd_maddr c%0d: got %h want %h", k, am.addr, ad[g]); end
      n_cmp++; if (am.write !== wr[g]) begin n_err++; $display("FAIL rnd_mwrite c%0d: got %b want %b", k, am.write, wr[g]); end
      n_cmp++; if ({a0.ack, a1.ack} !== exp_ack) begin n_err++; $display("FAIL rnd_ack c%0d: got %b%b want %b", k, a0.ack, a1.ack, exp_ack); end
      n_cmp++; if ({a0.last, a1.last} !== exp_last) begin n_err++; $display("FAIL rnd_last c%0d: got %b%b want %b", k, a0.last, a1.last, exp_last); end
      n_cmp++; if (a0.done !== ((resp_src == 0) ? dn : 4'h0)) begin n_err++; $display("FAIL rnd_done0 c%0d: got %b src %0d", k, a0.done, resp_src); end
      n_cmp++; if (a1.done !== ((resp_src == 1) ? dn : 4'h0)) begin n_err++; $display("FAIL rnd_done1 c%0d: got %b src %0d", k, a1.done, resp_src); end
      n_cmp++; if (a1.rdata !== ((resp_src == 1) ? rd : 32'h0)) begin n_err++; $display("FAIL rnd_rdata1 c%0d: got %h src %0d", k, a1.rdata, resp_src); end
      done_due = lst;
      done_wr  = dph_wr;
      if (lst) begin resp_src = dph_src; dph_busy = 0; end
      if (ack) begin
        last_g = g; hold = (lk[g] || ct[g]) ? g : -1;
        dph_src = g; dph_busy = 1; dph_wr = wr[g];
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_round_robin();
    test_fixed_priority();
    test_held_burst();
    test_busy();
    test_overlap();
    test_reset_mid_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bus_m_arb2.md
# bus_m_arb2

Two-to-one bus master arbiter placed directly upstream of the AHB bus master stage. It merges two command sources onto the single BUS_M command interface: source 0 is the data-side LSU, source 1 is instruction fetch or the debug system bus. It grants in round-robin or fixed priority, and holds the grant across locked and continuing bursts. It also tracks which source owns the data phase and the done cycle, so it can route LAST, DONE and RDATA back to the correct requester.

## Interface
- FIXED_PRI, default 0: 0 selects round-robin; 1 gives S0 fixed priority over S1.
- CLK  input  1  System clock.
- RES_SYS  input  1  System reset; asynchronous, active-high.
- S0_REQ, S1_REQ  input  1  Source command request.
- S0_ACK, S1_ACK  output  1  Source command acknowledge.
- S0_SEQ/S1_SEQ, S0_CONT/S1_CONT, S0_LOCK/S1_LOCK, S0_WRITE/S1_WRITE  input  1 each  Source command attributes.
- S0_BURST/S1_BURST  input  3  Burst type.
- S0_PROT/S1_PROT  input  4  Protection.
- S0_SIZE/S1_SIZE  input  2  Size: 0 byte, 1 halfword, 2 word.
- S0_ADDR/S1_ADDR, S0_WDATA/S1_WDATA  input  32  Address and write data.
- S0_LAST, S1_LAST  output  1  Data-phase last cycle, routed to the source.
- S0_RDATA/S1_RDATA  output  32  Routed read data.
- S0_DONE/S1_DONE  output  4  Routed done, {BUSERR, EXCEPTION, WRITE, DONE}.
- M_REQ, M_SEQ, M_CONT, M_LOCK, M_WRITE  output  1  Downstream command.
- M_BURST  output  3  Downstream burst type.
- M_PROT  output  4  Downstream protection.
- M_SIZE  output  2  Downstream size.
- M_ADDR, M_WDATA  output  32  Downstream address and write data.
- M_ACK, M_LAST  input  1  Downstream acknowledge and last cycle.
- M_RDATA  input  32  Downstream read data, registered.
- M_DONE  input  4  Downstream done, registered, one-cycle pulse.

## Operation
- Registers:
  - `locked` (1 bit), `owner` (1 bit): grant hold.
  - `last_win` (1 bit): round-robin pointer.
  - `dph_own` (1 bit): owner of the current data phase.
  - `done_own` (1 bit): owner of the current done cycle.
- Selection `sel` (combinational):
  - If `locked`, `sel` = `owner`.
  - Else if only one source requests, `sel` = that source.
  - Else if both request: `sel` = 0 when FIXED_PRI=1; otherwise `sel` = ~`last_win`.
  - Else `sel` = `last_win`.
- All M_* command outputs mux from source `sel`. When the muxed source's REQ is 0, M_CONT still reflects that source's CONT, so the downstream stage issues BUSY rather than IDLE inside a held burst.
- Acknowledge routing:
  - S{sel}_ACK = M_ACK.
  - The other ACK is 0.
  - The ACK path is combinational, with no added latency.
- On M_ACK:
  - `last_win` <= `sel`, `owner` <= `sel`.
  - `locked` <= S{sel}_LOCK | S{sel}_CONT.
  - `dph_own` <= `sel`.
- A locked grant releases only on an M_ACK whose command has LOCK=0 and CONT=0. The other source waits meanwhile, even if the owner drops REQ.
- Response routing:
  - On M_LAST, `done_own` <= `dph_own`.
  - S{dph_own}_LAST = M_LAST; the other LAST is 0.
  - S{done_own}_DONE = M_DONE and S{done_own}_RDATA = M_RDATA; the other source sees 0 on both.
- States, encoded by `locked`:
  - OPEN (`locked`=0): arbitrate every cycle.
  - HELD (`locked`=1): grant frozen to `owner`.
  - OPEN -> HELD on M_ACK with LOCK|CONT.
  - HELD -> OPEN on M_ACK with ~LOCK & ~CONT.

## Timing
- Reset values:
  - `locked`=0, `owner`=0, `last_win`=1 (S0 wins the first tie), `dph_own`=0, `done_own`=0.
  - All S*_ACK, S*_LAST, S*_DONE, S*_RDATA = 0.
  - M_REQ=0 and M_CONT=0 while S1 is idle.
- Acknowledge latency: S_REQ to S_ACK is zero cycles when M_ACK is high.
- Pipeline from an ACK in cycle N:
  - LAST is routed in the data phase, cycle N+1 or later depending on wait states.
  - DONE and RDATA are routed in the cycle after LAST.
- Pipelined overlap:
  - An ACK for source B can coincide with LAST for source A.
  - `dph_own` updates to B at the clock edge; LAST in that cycle still routes to A.
  - `done_own` samples the old `dph_own` (A), so DONE in the next cycle goes to A.
- Request withdrawal: if a source drops REQ before ACK, the arbiter re-evaluates next cycle with no penalty.
- Reset mid-transfer: all routing registers clear asynchronously. Any pending DONE is not forwarded after reset.

## Test plan
- Round-robin tie: FIXED_PRI=0, S0 and S1 request word reads continuously with M_ACK=1 every cycle. Required: ACK order S0, S1, S0, S1. S0_DONE carries RDATA 0x11111111 and S1_DONE carries 0x22222222, each one cycle after its LAST.
- Fixed priority: FIXED_PRI=1, both request for 4 cycles. Required: only S0_ACK pulses; S1_ACK stays 0 until S0_REQ=0.
- Held burst: S1 issues 4 commands with CONT=1,1,1,0 while S0 requests throughout. Required: S0_ACK=0 until the fourth S1 ACK, then S0 is acked on the next M_ACK.
- BUSY inside a held burst: S1 holds LOCK with REQ=0 and CONT=1 for 2 cycles. Required: M_REQ=0, M_CONT=1, and S0 is not granted.
- Overlap with wait state: S0 write acked; its data phase has 1 wait state (M_LAST low, then high); S1 read acked in the M_LAST cycle. Required: S0_DONE=4'b0011, then S1_DONE=4'b0001 with M_RDATA on S1_RDATA. S1_DONE and S0_DONE are never nonzero in the same cycle.
- Reset mid-burst: assert RES_SYS while HELD with a done pending. Required: next cycle after release, `locked`=0 and all S*_DONE=0, and the first tie goes to S0.
